// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared types, codes and helpers for the load/store unit bus controller.
package lsu_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    function automatic logic [BUS_W-1:0] bswap32(input logic [BUS_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    // Unsupported width codes and misaligned addresses are both rejected.
    function automatic logic req_bad(input logic wr, input logic [2:0] f3, input logic [1:0] a);
        logic ill;
        logic mis;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
        mis = ((f3[1:0] == 2'b10) && (a != 2'b00)) || ((f3[1:0] == 2'b01) && a[0]);
        return ill || mis;
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// External memory bus: address/data strobes from the controller, data and ack from memory.
interface lsu_bus_ctrl_if;
    logic [lsu_pkg::BUS_W-1:0] DAD;
    logic                      MREQ;
    logic                      WRITE;
    logic [1:0]                SIZE;
    logic [lsu_pkg::BUS_W-1:0] DDT_o;
    logic                      DDT_oe;
    logic [lsu_pkg::BUS_W-1:0] DDT_i;
    logic                      ACKD_n;

    modport master (output DAD, MREQ, WRITE, SIZE, DDT_o, DDT_oe, input DDT_i, ACKD_n);
    modport slave  (input DAD, MREQ, WRITE, SIZE, DDT_o, DDT_oe, output DDT_i, ACKD_n);
endinterface

// File: rtl/lsu_bus_ctrl_load_extend.sv
// Combinational load result formatting: sign/zero extension and optional word byte swap.
module load_extend
    import lsu_pkg::*;
#(
    parameter bit SWAP = 1'b0
) (
    input  logic [2:0]       funct3,
    input  logic [BUS_W-1:0] ddt_i,
    output logic [BUS_W-1:0] rdata
);

    // Select extension by access width and signedness
    always_comb begin
        case (funct3)
            F3_B:    rdata = {{24{ddt_i[7]}}, ddt_i[7:0]};
            F3_H:    rdata = {{16{ddt_i[15]}}, ddt_i[15:0]};
            F3_BU:   rdata = {24'h000000, ddt_i[7:0]};
            F3_HU:   rdata = {16'h0000, ddt_i[15:0]};
            F3_W:    rdata = SWAP ? bswap32(ddt_i) : ddt_i;
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// MEM-stage load/store bus controller: IDLE/BUSY/RESP handshake with wait-cycle timeout.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit BUS_SWAP_WORD  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [BUS_W-1:0] req_addr,
    input  logic [BUS_W-1:0] req_wdata,
    output logic             stall,
    output logic             rdata_valid,
    output logic [BUS_W-1:0] rdata,
    output logic             misalign,
    output logic             bus_timeout,
    lsu_bus_ctrl_if.master   bus
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [BUS_W-1:0] addr_q, addr_d;
    logic [BUS_W-1:0] wdata_q, wdata_d;
    logic [BUS_W-1:0] rdata_q, rdata_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             write_q, write_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUS_W-1:0] ext_s;
    logic [BUS_W-1:0] wfmt_s;
    logic             bad_s;
    logic             stall_s;
    logic             misalign_s;

    load_extend #(.SWAP(BUS_SWAP_WORD)) u_load_extend (
        .funct3 (funct3_q),
        .ddt_i  (bus.DDT_i),
        .rdata  (ext_s)
    );

    // Request legality and bus-side store data formatting
    always_comb begin
        bad_s = req_bad(req_write, req_funct3, req_addr[1:0]);
        case (req_funct3[1:0])
            2'b00:   wfmt_s = {24'h000000, req_wdata[7:0]};
            2'b01:   wfmt_s = {16'h0000, req_wdata[15:0]};
            default: wfmt_s = BUS_SWAP_WORD ? bswap32(req_wdata) : req_wdata;
        endcase
    end

    // Next-state, capture and handshake logic
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        write_d    = write_q;
        rdata_d    = rdata_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        stall_s    = 1'b0;
        misalign_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timeout_d = 1'b0;
                if (req_valid && bad_s) begin
                    misalign_s = 1'b1;
                end else if (req_valid) begin
                    stall_s  = 1'b1;
                    addr_d   = req_addr;
                    wdata_d  = wfmt_s;
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                // An ack on the final wait cycle still completes normally.
                if (!bus.ACKD_n) begin
                    rdata_d = write_q ? rdata_q : ext_s;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    rdata_d   = 32'h0000_0000;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            rdata_q   <= 32'h0000_0000;
            funct3_q  <= 3'b000;
            write_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            funct3_q  <= funct3_d;
            write_q   <= write_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Bus and core outputs decoded from the registered state
    always_comb begin
        bus.MREQ    = (state_q == ST_BUSY);
        bus.DAD     = bus.MREQ ? addr_q : 32'h0000_0000;
        bus.WRITE   = bus.MREQ && write_q;
        bus.SIZE    = bus.MREQ ? size_of(funct3_q) : SIZE_WORD;
        bus.DDT_oe  = bus.MREQ && write_q;
        bus.DDT_o   = bus.DDT_oe ? wdata_q : 32'h0000_0000;
        stall       = stall_s;
        misalign    = misalign_s;
        rdata       = rdata_q;
        rdata_valid = (state_q == ST_RESP) && !write_q && !timeout_q;
        bus_timeout = (state_q == ST_RESP) && timeout_q;
    end

endmodule
